// File: rtl/im_vga_reader.sv
// ---------------------------------------------------------------------------
// im_vga_reader
//
// Read-side consumer of the image memory (IM). Generates VGA raster timing,
// fetches one IM word per pixel inside the image window (row-major, top-left
// of the active area) and drives the video pins. Active pixels outside the
// window show BG; blanking shows 0.
//
// Pipeline (fixed 3-clock latency from counter position to pins):
//   stage 0 : hcnt / vcnt / acnt counters and position decode
//   stage 1 : registered IM request (im_r_en / im_r_addr) + control bits
//   stage 2 : IM returns im_r_data; control bits delayed one more clock
//   stage 3 : registered video outputs
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           raster enable; dropping it abandons the frame
//   im_r_en      IM read enable (only asserted inside the image window)
//   im_r_addr    IM read address (holds its last value between reads)
//   im_r_data    IM read data, valid one clock after im_r_en
//   vga_pixel    pixel value
//   vga_hsync    horizontal sync, active level SYNC_POL
//   vga_vsync    vertical sync, active level SYNC_POL
//   vga_de       active-video flag
//   frame_start  one-clock pulse with the first active pixel of each frame
// ---------------------------------------------------------------------------
module im_vga_reader #(
    parameter int                 IM_ADDR_W = 15,
    parameter int                 IM_DATA_W = 8,
    parameter int                 H_ACTIVE  = 640,
    parameter int                 H_FP      = 16,
    parameter int                 H_SYNC    = 96,
    parameter int                 H_BP      = 48,
    parameter int                 V_ACTIVE  = 480,
    parameter int                 V_FP      = 10,
    parameter int                 V_SYNC    = 2,
    parameter int                 V_BP      = 33,
    parameter int                 IMG_W     = 160,
    parameter int                 IMG_H     = 120,
    parameter bit                 SYNC_POL  = 1'b0,
    parameter logic [IM_DATA_W-1:0] BG      = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 im_r_en,
    output logic [IM_ADDR_W-1:0] im_r_addr,
    input  logic [IM_DATA_W-1:0] im_r_data,
    output logic [IM_DATA_W-1:0] vga_pixel,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_de,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra count of headroom so the sync-end bounds always fit, even
    // with a zero back porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG_C  = HW'(IMG_W);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE    = HW'(1);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG_C  = VW'(IMG_H);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE    = VW'(1);

    localparam logic [IM_ADDR_W-1:0] A_LAST = IM_ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [IM_ADDR_W-1:0] A_ONE  = IM_ADDR_W'(1);

    // -----------------------------------------------------------------------
    // Stage 0: raster counters
    // -----------------------------------------------------------------------
    // 'run' marks that the counters hold a real raster position. It is set
    // on the clock that samples en high, so position (0,0) is presented on
    // the following cycle; while it is low the decode is forced idle.
    logic                 run;
    logic [HW-1:0]        hcnt;
    logic [VW-1:0]        vcnt;
    logic [IM_ADDR_W-1:0] acnt;

    logic act0, win0, hs0, vs0, fs0;
    logic h_wrap, frame_wrap;

    assign h_wrap     = (hcnt == H_LAST);
    assign frame_wrap = h_wrap && (vcnt == V_LAST);

    always_comb begin
        act0 = run && (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        win0 = run && (hcnt < H_IMG_C) && (vcnt < V_IMG_C);
        hs0  = run && (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs0  = run && (vcnt >= VS_BEG) && (vcnt < VS_END);
        fs0  = run && (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
            acnt <= '0;
        end else if (!en) begin
            // Abandon the frame; the next enable restarts at address 0.
            run  <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
            acnt <= '0;
        end else if (!run) begin
            run  <= 1'b1;
        end else begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + V_ONE;
            end else begin
                hcnt <= hcnt + H_ONE;
            end

            // Row-major address follows window pixels directly; the clamp
            // keeps it inside the image after the last window pixel.
            if (frame_wrap) begin
                acnt <= '0;
            end else if (win0 && (acnt != A_LAST)) begin
                acnt <= acnt + A_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: registered IM request and control bits
    // -----------------------------------------------------------------------
    // Gated by en so the request stops on the same clock that samples en low;
    // the address is kept so the IM port stays quiet between reads.
    logic act1, win1, hs1, vs1, fs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_r_en   <= 1'b0;
            im_r_addr <= '0;
            act1      <= 1'b0;
            win1      <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            fs1       <= 1'b0;
        end else if (!en) begin
            im_r_en   <= 1'b0;
            act1      <= 1'b0;
            win1      <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            fs1       <= 1'b0;
        end else begin
            im_r_en   <= win0;
            act1      <= act0;
            win1      <= win0;
            hs1       <= hs0;
            vs1       <= vs0;
            fs1       <= fs0;
            if (win0) begin
                im_r_addr <= acnt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: control bits wait for the IM read data
    // -----------------------------------------------------------------------
    logic act2, win2, hs2, vs2, fs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act2 <= 1'b0;
            win2 <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            fs2  <= 1'b0;
        end else begin
            act2 <= act1;
            win2 <= win1;
            hs2  <= hs1;
            vs2  <= vs1;
            fs2  <= fs1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: registered video outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_pixel   <= '0;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
        end else begin
            if (act2) begin
                vga_pixel <= win2 ? im_r_data : BG;
            end else begin
                vga_pixel <= '0;
            end
            vga_de      <= act2;
            frame_start <= fs2;
            vga_hsync   <= hs2 ? SYNC_POL : ~SYNC_POL;
            vga_vsync   <= vs2 ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_im_vga_reader.sv
// ---------------------------------------------------------------------------
// tb_im_vga_reader
//
// Small raster: H 4/1/2/1 (8 clocks/line), V 3/1/1/1 (6 lines/frame),
// 2x2 image window. IM model returns 0xA0+addr one clock after a read.
// Expected values come from a raster model of the video timing, indexed by
// the clock on which en was first sampled high.
// ---------------------------------------------------------------------------
module tb_im_vga_reader;

    localparam int NVEC    = 189;
    localparam int FIRST_S = 20;   // first en-high vector
    localparam int DROP_I  = 126;  // en sampled low at raster position (1,1)
    localparam int SECOND_S = 136; // re-enable vector
    localparam int NO_STOP = 100000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       im_r_en;
    logic [1:0] im_r_addr;
    logic [7:0] im_r_data = 8'h00;
    logic [7:0] vga_pixel;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_de;
    logic       frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit       en;
        bit       de;
        bit [7:0] pix;
        bit       hs;
        bit       vs;
        bit       fs;
        bit       ren;
        bit [1:0] addr;
    } vec_t;

    vec_t tbl [NVEC];

    im_vga_reader #(
        .IM_ADDR_W (2),
        .IM_DATA_W (8),
        .H_ACTIVE  (4),
        .H_FP      (1),
        .H_SYNC    (2),
        .H_BP      (1),
        .V_ACTIVE  (3),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .IMG_W     (2),
        .IMG_H     (2),
        .SYNC_POL  (1'b0),
        .BG        (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .im_r_en     (im_r_en),
        .im_r_addr   (im_r_addr),
        .im_r_data   (im_r_data),
        .vga_pixel   (vga_pixel),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_r_en) im_r_data <= 8'hA0 + {6'd0, im_r_addr};
    end

    // Raster model. i: vector index, base: vector that first sampled en high,
    // stop: vector that sampled en low (positions after it are never fetched).
    function automatic vec_t model(int i, int base, int stop, bit en_i);
        vec_t v;
        int jo, jr, lim, h, l;
        jo  = i - base - 3;
        jr  = i - base - 1;
        lim = stop - base - 2;
        v.en = en_i; v.de = 1'b0; v.pix = 8'h00; v.hs = 1'b1; v.vs = 1'b1;
        v.fs = 1'b0; v.ren = 1'b0; v.addr = 2'd0;
        if (jo >= 0 && jo <= lim) begin
            h = jo % 8;
            l = (jo / 8) % 6;
            v.de  = (h < 4) && (l < 3);
            v.pix = ((h < 2) && (l < 2)) ? 8'(8'hA0 + l * 2 + h) : 8'h00;
            v.hs  = !((h >= 5) && (h < 7));
            v.vs  = (l != 4);
            v.fs  = (jo % 48 == 0);
        end
        if (jr >= 0 && jr <= lim) begin
            h = jr % 8;
            l = (jr / 8) % 6;
            v.ren  = (h < 2) && (l < 2);
            v.addr = 2'(l * 2 + h);
        end
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_vec(int idx, vec_t e);
        check("vga_de",      idx, {31'd0, vga_de},      {31'd0, e.de});
        check("vga_pixel",   idx, {24'd0, vga_pixel},   {24'd0, e.pix});
        check("vga_hsync",   idx, {31'd0, vga_hsync},   {31'd0, e.hs});
        check("vga_vsync",   idx, {31'd0, vga_vsync},   {31'd0, e.vs});
        check("frame_start", idx, {31'd0, frame_start}, {31'd0, e.fs});
        check("im_r_en",     idx, {31'd0, im_r_en},     {31'd0, e.ren});
        check("im_r_addr",   idx, {30'd0, im_r_addr},   {30'd0, e.addr});
    endtask

    task automatic check_reset_vals(string tag);
        vec_t e;
        e = model(0, NO_STOP, 0, 1'b0);
        check_vec(-1, e);
        if (vga_de !== 1'b0 || im_r_en !== 1'b0)
            $display("  (%s)", tag);
    endtask

    initial begin
        bit [1:0] last_addr;
        vec_t     e;

        // Build the vector table: idle, one run of just over two frames with
        // en dropped at (1,1) of the third, idle again, then a restart.
        last_addr = 2'd0;
        for (int i = 0; i < NVEC; i++) begin
            bit en_i;
            int base, stop;
            en_i = ((i >= FIRST_S) && (i < DROP_I)) || (i >= SECOND_S);
            base = (i >= SECOND_S) ? SECOND_S : FIRST_S;
            stop = (i >= SECOND_S) ? NO_STOP : DROP_I;
            tbl[i] = model(i, base, stop, en_i);
            if (tbl[i].ren) last_addr = tbl[i].addr;
            else            tbl[i].addr = last_addr;
        end

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset held");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            en = tbl[i].en;
            @(posedge clk);
            #1;
            check_vec(i, tbl[i]);
        end

        // Output is now pixel A1 on line 0 of a frame: reset mid-line.
        check("pre_rst_pixel", -1, {24'd0, vga_pixel}, 32'hA1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async reset");
        @(posedge clk);
        #1;
        check_reset_vals("reset held");
        rst = 1'b0;

        // en is still high; the first edge after release starts a new frame.
        last_addr = 2'd0;
        for (int k = 0; k < 55; k++) begin
            @(posedge clk);
            #1;
            e = model(k, 0, NO_STOP, 1'b1);
            if (e.ren) last_addr = e.addr;
            else       e.addr = last_addr;
            check_vec(1000 + k, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_vga_reader.md
Name: im_vga_reader

Overview:
- Read-side consumer of the image memory (IM) read port (im_r_en / im_r_addr / im_r_data). Replaces the testbench linear-scan reader.
- Generates VGA raster timing and fetches one IM word per in-window pixel, row-major.
- Aligns the returned data with hsync/vsync/data-enable and drives the video pins.
- Image window is IMG_W x IMG_H at the top-left of the active area; all other active pixels show BG.

Parameters:
IM_ADDR_W  15  IM address width; 2**IM_ADDR_W >= IMG_W*IMG_H
IM_DATA_W  8  IM word / pixel width
H_ACTIVE, H_FP, H_SYNC, H_BP  640, 16, 96, 48  horizontal timing in clocks
V_ACTIVE, V_FP, V_SYNC, V_BP  480, 10, 2, 33  vertical timing in lines
IMG_W, IMG_H  160, 120  image window size; IMG_W <= H_ACTIVE, IMG_H <= V_ACTIVE
SYNC_POL  0  sync active level (0 = active-low)
BG  0  pixel value outside the window

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  raster enable
im_r_en  out  1  IM read enable
im_r_addr  out  IM_ADDR_W  IM read address
im_r_data  in  IM_DATA_W  IM read data, valid 1 cycle after im_r_en
vga_pixel  out  IM_DATA_W  pixel value
vga_hsync  out  1  horizontal sync
vga_vsync  out  1  vertical sync
vga_de  out  1  active-video flag
frame_start  out  1  1-cycle pulse with first active pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (async):
  - counters, address counter and all pipeline registers cleared.
  - im_r_en=0, im_r_addr=0, vga_pixel=0, vga_de=0, frame_start=0.
  - vga_hsync=vga_vsync=~SYNC_POL.
- Stage 0 (counters):
  - hcnt runs 0..H_TOTAL-1, then wraps to 0 and increments vcnt.
  - vcnt runs 0..V_TOTAL-1, then wraps to 0.
  - Counters advance only while en=1.
- Decode from stage 0:
  - act = hcnt<H_ACTIVE && vcnt<V_ACTIVE
  - win = hcnt<IMG_W && vcnt<IMG_H
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - fs = hcnt==0 && vcnt==0
- Address counter acnt:
  - Increments by 1 on each win cycle; no multiplier.
  - Cleared on the cycle where hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1 (frame wrap).
  - Never exceeds IMG_W*IMG_H-1.
- Stage 1 (registered IM request):
  - im_r_en <= win.
  - im_r_addr <= acnt when win; otherwise holds its last value.
  - Control bits act, win, hs, vs, fs are pipelined alongside.
- Stage 2: IM returns im_r_data, valid for the stage-1 request.
- Stage 3 (registered outputs):
  - vga_pixel <= win2 ? im_r_data : BG when act2; 0 when !act2.
  - vga_de <= act2; frame_start <= fs2.
  - vga_hsync <= hs2 ? SYNC_POL : ~SYNC_POL; vga_vsync likewise.
- Latency: fixed 3 clocks from counter position to pins, identical for all outputs, so syncs, de and pixel stay mutually aligned.
- en=0:
  - Next cycle hcnt, vcnt and acnt are forced to 0 and im_r_en=0.
  - The pipeline drains over 3 cycles to idle levels (reset values), then holds.
- en rising:
  - The first stage-0 position (0,0) occurs on the cycle after en is sampled high.
  - frame_start appears 3 cycles after that position.
- en falling mid-frame: the frame is abandoned; the next enable restarts at address 0 (no resume).
- IM is read only inside the window. No reads during blanking or outside the window.
- Reset mid-frame: immediate return to reset values. No IM access until en is re-sampled after rst drops.

Test Plan:
Small config for all scenarios: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), IMG 2x2, IM_ADDR_W=2, SYNC_POL=0. Memory model: 1-cycle latency, returns 0xA0+addr.
- Reset with en=0, 20 clocks -> im_r_en=0, vga_de=0, vga_pixel=0, hsync=vsync=1 throughout.
- en=1, one frame (48 clks) -> im_r_addr sequence 0,1 (line 0), 2,3 (line 1), exactly 4 reads. vga_pixel on line 0 = A0,A1,00,00 and line 1 = A2,A3,00,00, with vga_de=1 on those 4 cycles. Line 2: de=1, pixel 00.
- Timing check -> hsync low for 2 clocks starting 5 clocks after a line's first active pixel. vsync low for exactly line 4 (8 clocks). frame_start high once per 48 clocks, coincident with pixel A0.
- Two consecutive frames -> address wraps to 0 at frame 2. Frame 2 pixels identical to frame 1. No read to address 0 outside the window.
- en dropped at (hcnt=1, vcnt=1) -> at most the 3 in-flight pixels emitted, then idle. Re-enable -> first read is address 0, frame_start 4 clocks after en sampled.
- rst asserted mid-line 0 -> all outputs at reset values within the same cycle (async). Normal frame resumes after release with en=1.
